// File: rtl/srl_start_fifo_ctrl_pkg.sv
// Shared sizing helpers for the SRL start-token FIFO controller and its storage.
`timescale 1ns/1ps
package srl_start_fifo_ctrl_pkg;

  // The occupancy counter needs one bit more than the read address so it can hold DEPTH itself.
  localparam int COUNT_EXTRA_BITS = 1;

  function automatic int addr_width_for(input int depth);
    int w;
    w = 1;
    while ((1 << w) < depth) w++;
    return w;
  endfunction

  function automatic int count_width(input int addr_width);
    return addr_width + COUNT_EXTRA_BITS;
  endfunction

endpackage

// File: rtl/srl_start_fifo_ctrl_storage.sv
// DEPTH x DATA_WIDTH shift register: new words enter slot 0 and the read port is a plain mux.
`timescale 1ns/1ps
module srl_fifo_storage #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] srl_q [DEPTH];

  // No reset on purpose: occupancy lives in the controller, so stale slots are never observed.
  always_ff @(posedge clk) begin
    if (we) begin
      srl_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        srl_q[i] <= srl_q[i-1];
      end
    end
  end

  assign dout = srl_q[addr];

endmodule

// File: rtl/srl_start_fifo_ctrl.sv
// FIFO controller around the SRL storage: occupancy, read address and registered handshake flags.
`timescale 1ns/1ps
module srl_start_fifo_ctrl
  import srl_start_fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic [ADDR_WIDTH:0]   if_num_data_valid
);

  localparam int CW     = count_width(ADDR_WIDTH);
  localparam int MIN_AW = addr_width_for(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [CW-1:0]         count_q, count_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  empty_n_q, full_n_q;
  logic                  push, pop;

  assign push = if_write & full_n_q;
  assign pop  = if_read & empty_n_q;

  // addr always points at the oldest word, i.e. count-1 (or 0 when empty).
  always_comb begin
    count_d = count_q;
    addr_d  = addr_q;
    unique case ({push, pop})
      2'b10: begin
        count_d = count_q + CW'(1);
        addr_d  = (count_q != '0) ? addr_q + ADDR_WIDTH'(1) : '0;
      end
      2'b01: begin
        count_d = count_q - CW'(1);
        addr_d  = (count_q > CW'(1)) ? addr_q - ADDR_WIDTH'(1) : '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q   <= '0;
      addr_q    <= '0;
      empty_n_q <= 1'b0;
      full_n_q  <= 1'b1;
    end else begin
      count_q   <= count_d;
      addr_q    <= addr_d;
      empty_n_q <= (count_d != '0);
      full_n_q  <= (count_d != DEPTH_C);
    end
  end

  srl_fifo_storage #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_storage (
    .clk  (clk),
    .we   (push),
    .addr (addr_q),
    .din  (if_din),
    .dout (if_dout)
  );

  assign if_empty_n        = empty_n_q;
  assign if_full_n         = full_n_q;
  assign if_num_data_valid = count_q;

  a_addr_width: assert property (@(posedge clk) ADDR_WIDTH >= MIN_AW);
  a_count_max:  assert property (@(posedge clk) disable iff (reset) count_q <= DEPTH_C);
  a_addr_empty: assert property (@(posedge clk) disable iff (reset)
                                 (count_q == '0) |-> (addr_q == '0));
  a_addr_track: assert property (@(posedge clk) disable iff (reset)
                                 (count_q != '0) |-> ({1'b0, addr_q} == count_q - CW'(1)));

endmodule

// File: tb/tb_srl_start_fifo_ctrl.sv
// Drives DEPTH=2, 4 and 1 instances from one stimulus stream and checks each against a queue model.
`timescale 1ns/1ps
module tb_srl_start_fifo_ctrl;

  localparam int DEP [3] = '{2, 4, 1};

  logic       clk;
  logic       reset;
  logic       if_write;
  logic       if_read;
  logic [7:0] if_din;

  logic [7:0] dout_w    [3];
  logic       empty_n_w [3];
  logic       full_n_w  [3];
  logic [2:0] num_w     [3];
  logic [1:0] num_d2, num_d1;
  logic [2:0] num_d4;

  logic [7:0] mq [3][$];
  int tests_run = 0;
  int tests_failed = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  srl_start_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(1), .DEPTH(2)) u_d2 (
    .clk(clk), .reset(reset), .if_write(if_write), .if_din(if_din), .if_full_n(full_n_w[0]),
    .if_read(if_read), .if_dout(dout_w[0]), .if_empty_n(empty_n_w[0]), .if_num_data_valid(num_d2)
  );
  srl_start_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .DEPTH(4)) u_d4 (
    .clk(clk), .reset(reset), .if_write(if_write), .if_din(if_din), .if_full_n(full_n_w[1]),
    .if_read(if_read), .if_dout(dout_w[1]), .if_empty_n(empty_n_w[1]), .if_num_data_valid(num_d4)
  );
  srl_start_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(1), .DEPTH(1)) u_d1 (
    .clk(clk), .reset(reset), .if_write(if_write), .if_din(if_din), .if_full_n(full_n_w[2]),
    .if_read(if_read), .if_dout(dout_w[2]), .if_empty_n(empty_n_w[2]), .if_num_data_valid(num_d1)
  );

  assign num_w[0] = {1'b0, num_d2};
  assign num_w[1] = num_d4;
  assign num_w[2] = {1'b0, num_d1};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s d%0d empty_n", tag, DEP[k]), 32'(empty_n_w[k]), 32'(mq[k].size() != 0));
      check($sformatf("%s d%0d full_n", tag, DEP[k]), 32'(full_n_w[k]), 32'(mq[k].size() != DEP[k]));
      check($sformatf("%s d%0d count", tag, DEP[k]), 32'(num_w[k]), 32'(mq[k].size()));
      if (mq[k].size() != 0)
        check($sformatf("%s d%0d dout", tag, DEP[k]), 32'(dout_w[k]), 32'(mq[k][0]));
    end
  endtask

  // One clock: inputs applied from the falling edge, model advanced at the rising edge.
  task automatic step(input logic w, input logic [7:0] d, input logic r, input string tag);
    if_write = w;
    if_din   = d;
    if_read  = r;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      bit pu, po;
      pu = w && (mq[k].size() != DEP[k]);
      po = r && (mq[k].size() != 0);
      if (po) void'(mq[k].pop_front());
      if (pu) mq[k].push_back(d);
    end
    #1;
    check_all(tag);
    @(negedge clk);
    $display("[TB] %s w=%0d din=%02h r=%0d -> counts %0d/%0d/%0d", tag, w, d, r,
             mq[0].size(), mq[1].size(), mq[2].size());
  endtask

  // Reset asserted in the low phase, away from any edge; flags must drop without a clock.
  task automatic async_reset(input string tag);
    if_write = 1'b0;
    if_read  = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      mq[k].delete();
      check($sformatf("%s d%0d empty_n", tag, DEP[k]), 32'(empty_n_w[k]), 0);
      check($sformatf("%s d%0d full_n", tag, DEP[k]), 32'(full_n_w[k]), 1);
      check($sformatf("%s d%0d count", tag, DEP[k]), 32'(num_w[k]), 0);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_all({tag, " released"});
    $display("[TB] %s async reset applied", tag);
  endtask

  initial begin
    reset    = 1'b1;
    if_write = 1'b0;
    if_read  = 1'b0;
    if_din   = 8'h00;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b0, "idle");

    step(1'b1, 8'hA1, 1'b0, "push A1");
    step(1'b1, 8'hB2, 1'b0, "push B2");
    check("d2 full after 2 pushes", 32'(full_n_w[0]), 0);
    check("d2 count after 2 pushes", 32'(num_w[0]), 2);
    step(1'b1, 8'hC3, 1'b0, "push C3 while full");
    check("d2 head after ignored write", 32'(dout_w[0]), 32'h0000_00A1);
    step(1'b0, 8'h00, 1'b1, "pop A1");
    check("d2 head after 1st pop", 32'(dout_w[0]), 32'h0000_00B2);
    step(1'b0, 8'h00, 1'b1, "pop B2");
    check("d2 empty after 2 pops", 32'(empty_n_w[0]), 0);

    async_reset("rst before hold test");
    step(1'b1, 8'h11, 1'b0, "push 11");
    step(1'b1, 8'h22, 1'b1, "rw 22 with one held");
    check("d2 count stays 1", 32'(num_w[0]), 1);
    check("d2 dout becomes 22", 32'(dout_w[0]), 32'h0000_0022);

    step(1'b1, 8'h33, 1'b0, "fill d2");
    step(1'b1, 8'h44, 1'b1, "rw while d2 full");
    check("d2 count after full rw", 32'(num_w[0]), 1);
    check("d2 head after full rw", 32'(dout_w[0]), 32'h0000_0033);
    step(1'b0, 8'h00, 1'b1, "drain");
    step(1'b0, 8'h00, 1'b1, "drain");
    step(1'b0, 8'h00, 1'b1, "drain");
    step(1'b0, 8'h00, 1'b1, "drain");

    step(1'b1, 8'h5A, 1'b1, "rw while empty");
    check("d2 count after empty rw", 32'(num_w[0]), 1);
    check("d2 dout after empty rw", 32'(dout_w[0]), 32'h0000_005A);

    async_reset("rst before fill test");
    step(1'b1, 8'h01, 1'b0, "push 01");
    step(1'b1, 8'h02, 1'b0, "push 02");
    step(1'b1, 8'h03, 1'b0, "push 03");
    check("d4 count before reset", 32'(num_w[1]), 3);
    async_reset("rst mid fill");
    step(1'b1, 8'h77, 1'b0, "push 77 after reset");
    check("d4 new data only", 32'(dout_w[1]), 32'h0000_0077);
    step(1'b0, 8'h00, 1'b1, "pop 77");
    check("d4 empty after pop", 32'(empty_n_w[1]), 0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) async_reset("rand rst");
      else step(1'($urandom), 8'($urandom), 1'($urandom), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
